// File: rtl/apb_mem_responder.sv
// apb_mem_responder
//   APB3 completer in front of a word-addressed on-chip memory. It captures the
//   transfer at the setup edge, holds pready low for WAIT_STATES access cycles,
//   then returns pready/prdata/pslverr together on one registered edge.
//   Requester protocol violations raise proto_err for one cycle per offending edge.
//
// Ports
//   pclk      : clock, all logic on the rising edge
//   presetn   : asynchronous, active-low reset
//   psel      : select
//   penable   : access-phase indicator
//   pwrite    : 1 = write, 0 = read
//   paddr     : byte address (ADDR_WIDTH)
//   pwdata    : write data (DATA_WIDTH)
//   pready    : transfer complete (registered)
//   prdata    : read data (registered; 0 except on an error-free read completion)
//   pslverr   : transfer error, meaningful only while pready is high
//   proto_err : one-cycle pulse on a requester protocol violation
module apb_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  proto_err
);

  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [3:0]        WS    = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH * 4);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  // Misaligned or beyond the end of the memory.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= LIMIT);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  in_access;
  logic                  setup_edge;
  logic                  access_edge;
  logic                  complete;
  logic                  wait_step;
  logic                  abort;
  logic                  load_rsp;
  logic                  mismatch;
  logic                  proto_d;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic                  src_write;
  logic                  src_err;
  logic [IDX_W-1:0]      src_idx;

  always_comb begin
    in_access   = (state == ACCESS);
    setup_edge  = psel & ~penable;
    access_edge = psel & penable;
    complete    = in_access & access_edge & pready;
    wait_step   = in_access & access_edge & ~pready;
    abort       = in_access & ~psel;
    // A setup edge (in either state) starts a transfer; with no wait states the
    // response is produced on that same edge, so it must look at the live bus
    // rather than the not-yet-captured registers.
    load_rsp    = (setup_edge & (WS == 4'd0)) | (wait_step & (cnt == 4'd1));
    src_addr    = setup_edge ? paddr  : addr_q;
    src_write   = setup_edge ? pwrite : write_q;
    src_err     = addr_err(src_addr);
    src_idx     = src_addr[2 +: IDX_W];
    mismatch    = (paddr != addr_q) | (pwrite != write_q) |
                  (write_q & (pwdata != wdata_q));
    proto_d     = (~in_access & access_edge) |
                  abort |
                  (in_access & setup_edge) |
                  (in_access & access_edge & mismatch);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      pready    <= 1'b0;
      prdata    <= '0;
      pslverr   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= proto_d;

      if (setup_edge) begin
        state <= ACCESS;
        cnt   <= WS;
      end else if (abort || complete) begin
        state <= IDLE;
      end else if (wait_step) begin
        cnt <= cnt - 4'd1;
      end

      if (load_rsp) begin
        pready  <= 1'b1;
        pslverr <= src_err;
        prdata  <= (src_write || src_err) ? '0 : mem[src_idx];
      end else if (setup_edge || complete || abort) begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
        prdata  <= '0;
      end
    end
  end

  // Captured transfer attributes; only meaningful while in ACCESS, so no reset.
  always_ff @(posedge pclk) begin
    if (setup_edge) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (complete && write_q && !addr_err(addr_q)) begin
      mem[addr_q[2 +: IDX_W]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_mem_responder.sv
module tb_apb_mem_responder;

  localparam int ND = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel    [ND];
  logic        penable [ND];
  logic        pwrite  [ND];
  logic [31:0] paddr   [ND];
  logic [31:0] pwdata  [ND];
  logic        pready  [ND];
  logic [31:0] prdata  [ND];
  logic        pslverr [ND];
  logic        proto_err [ND];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int perr [ND];

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb [$];

  logic [31:0] mdl [ND][256];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  // Instance g has wait states 0, 2, 3, 5 respectively.
  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 5;
    apb_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(W)) u_dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .psel      (psel[g]),
      .penable   (penable[g]),
      .pwrite    (pwrite[g]),
      .paddr     (paddr[g]),
      .pwdata    (pwdata[g]),
      .pready    (pready[g]),
      .prdata    (prdata[g]),
      .pslverr   (pslverr[g]),
      .proto_err (proto_err[g])
    );
  end

  always @(negedge pclk) begin
    for (int i = 0; i < ND; i++) if (proto_err[i] === 1'b1) perr[i]++;
  end

  function automatic int ws(input int d);
    case (d)
      0: return 0;
      1: return 2;
      2: return 3;
      default: return 5;
    endcase
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Full transfer starting now (1 time unit after an edge); returns 1 time unit
  // after the completion edge with the bus idle, so a following call is back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   waits;
    int   p0;
    logic aerr;
    aerr   = (addr[1:0] != 2'b00) || (addr >= 32'h400);
    e.err  = aerr;
    e.data = (wr || aerr) ? 32'h0 : mdl[d][addr[9:2]];
    if (wr && !aerr) mdl[d][addr[9:2]] = wd;
    sb.push_back(e);
    p0 = perr[d];
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
    tick();
    penable[d] = 1'b1;
    waits = 0;
    while (pready[d] !== 1'b1 && waits < 40) begin
      n_tests++;
      if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_outputs dut%0d addr=%h: prdata=%h pslverr=%b, required 0/0", d, addr, prdata[d], pslverr[d]);
      end
      tick();
      waits++;
    end
    n_tests++;
    if (pready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL pready_timeout dut%0d addr=%h: pready=%b after %0d cycles, required 1", d, addr, pready[d], waits);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      if (waits != ws(d)) begin
        n_fail++;
        $display("FAIL wait_count dut%0d addr=%h: %0d, required %0d", d, addr, waits, ws(d));
      end
      n_tests++;
      if (prdata[d] !== e.data) begin
        n_fail++;
        $display("FAIL prdata dut%0d addr=%h: %h, required %h", d, addr, prdata[d], e.data);
      end
      n_tests++;
      if (pslverr[d] !== e.err) begin
        n_fail++;
        $display("FAIL pslverr dut%0d addr=%h: %b, required %b", d, addr, pslverr[d], e.err);
      end
    end
    tick();
    psel[d] = 1'b0; penable[d] = 1'b0;
    n_tests++;
    if (pready[d] !== 1'b0 || prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL post_complete dut%0d: pready=%b prdata=%h pslverr=%b, required 0/0/0", d, pready[d], prdata[d], pslverr[d]);
    end
    n_tests++;
    if (perr[d] != p0) begin
      n_fail++;
      $display("FAIL no_proto_err dut%0d addr=%h: %0d pulses, required 0", d, addr, perr[d] - p0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < ND; i++) begin
      n_tests++;
      if (pready[i] !== 1'b0 || prdata[i] !== 32'h0 || pslverr[i] !== 1'b0 || proto_err[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s dut%0d: pready=%b prdata=%h pslverr=%b proto_err=%b, required all 0",
                 tag, i, pready[i], prdata[i], pslverr[i], proto_err[i]);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < ND; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0; perr[i] = 0;
    end
    presetn = 1'b0;
    tick();
    tick();
    check_all_zero("reset_values");
    presetn = 1'b1;
    tick();
  endtask

  task automatic test_w0();
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h10, 32'h0);
    tick();
  endtask

  task automatic test_w3();
    xfer(2, 1'b1, 32'h0, 32'h12345678);
    tick();
    xfer(2, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_errors();
    xfer(0, 1'b1, 32'h0, 32'h11111111);
    xfer(0, 1'b1, 32'h402, 32'hAA);       // misaligned; index aliases word 0
    xfer(0, 1'b0, 32'h400, 32'h0);        // out of range; index aliases word 0
    xfer(0, 1'b0, 32'h0, 32'h0);          // word 0 must be untouched
    xfer(2, 1'b0, 32'h3FE, 32'h0);        // misaligned read
    tick();
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    xfer(1, 1'b1, 32'h4, 32'hA5A5A5A5);
    xfer(1, 1'b0, 32'h4, 32'h0);
    xfer(1, 1'b1, 32'h8, 32'h5A5A5A5A);
    xfer(1, 1'b0, 32'h8, 32'h0);
    n_tests++;
    if (cyc - c0 != 4 * (ws(1) + 2)) begin
      n_fail++;
      $display("FAIL b2b_cycles: %0d, required %0d", cyc - c0, 4 * (ws(1) + 2));
    end
    tick();
  endtask

  task automatic test_proto_noset();
    int p0;
    p0 = perr[0];
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'h10;
    tick();
    psel[0] = 1'b0; penable[0] = 1'b0;
    n_tests++;
    if (proto_err[0] !== 1'b1 || pready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL noset_pulse: proto_err=%b pready=%b, required 1/0", proto_err[0], pready[0]);
    end
    tick();
    n_tests++;
    if (proto_err[0] !== 1'b0 || pready[0] !== 1'b0 || perr[0] != p0 + 1) begin
      n_fail++;
      $display("FAIL noset_after: proto_err=%b pready=%b pulses=%0d, required 0/0/1", proto_err[0], pready[0], perr[0] - p0);
    end
    tick();
  endtask

  task automatic test_proto_addr();
    int   p0;
    exp_t e;
    xfer(1, 1'b1, 32'h24, 32'h66);
    tick();
    p0 = perr[1];
    e.data = 32'h0; e.err = 1'b0;
    sb.push_back(e);
    mdl[1][8] = 32'h55;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h20; pwdata[1] = 32'h55;
    tick();
    penable[1] = 1'b1; paddr[1] = 32'h24;   // address changes for one access edge
    tick();
    n_tests++;
    if (proto_err[1] !== 1'b1 || pready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_change_pulse: proto_err=%b pready=%b, required 1/0", proto_err[1], pready[1]);
    end
    paddr[1] = 32'h20;
    tick();
    n_tests++;
    if (proto_err[1] !== 1'b0 || pready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_change_cont: proto_err=%b pready=%b, required 0/1", proto_err[1], pready[1]);
    end
    e = sb.pop_front();
    n_tests++;
    if (prdata[1] !== e.data || pslverr[1] !== e.err) begin
      n_fail++;
      $display("FAIL addr_change_rsp: prdata=%h pslverr=%b, required %h/%b", prdata[1], pslverr[1], e.data, e.err);
    end
    tick();
    psel[1] = 1'b0; penable[1] = 1'b0;
    tick();
    n_tests++;
    if (perr[1] != p0 + 1) begin
      n_fail++;
      $display("FAIL addr_change_count: %0d pulses, required 1", perr[1] - p0);
    end
    xfer(1, 1'b0, 32'h20, 32'h0);
    xfer(1, 1'b0, 32'h24, 32'h0);
    tick();
  endtask

  task automatic test_abort();
    int p0;
    xfer(2, 1'b1, 32'h30, 32'h77);
    tick();
    p0 = perr[2];
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h30; pwdata[2] = 32'h99;
    tick();
    penable[2] = 1'b1;
    tick();
    psel[2] = 1'b0; penable[2] = 1'b0;
    tick();
    n_tests++;
    if (proto_err[2] !== 1'b1 || pready[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pulse: proto_err=%b pready=%b, required 1/0", proto_err[2], pready[2]);
    end
    tick();
    n_tests++;
    if (proto_err[2] !== 1'b0 || perr[2] != p0 + 1) begin
      n_fail++;
      $display("FAIL abort_after: proto_err=%b pulses=%0d, required 0/1", proto_err[2], perr[2] - p0);
    end
    xfer(2, 1'b0, 32'h30, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    xfer(3, 1'b1, 32'h40, 32'hCAFEF00D);
    tick();
    psel[3] = 1'b1; penable[3] = 1'b0; pwrite[3] = 1'b1; paddr[3] = 32'h40; pwdata[3] = 32'h0BADBEEF;
    tick();
    penable[3] = 1'b1;
    tick();
    tick();
    #2;
    presetn = 1'b0;
    psel[3] = 1'b0; penable[3] = 1'b0;
    #1;
    check_all_zero("reset_mid_async");
    tick();
    check_all_zero("reset_mid_held");
    presetn = 1'b1;
    tick();
    xfer(3, 1'b0, 32'h40, 32'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_w0();
    test_w3();
    test_errors();
    test_back_to_back();
    test_proto_noset();
    test_proto_addr();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
